aes_round_sched: RTL and testbench

- Iterative AES-128 round scheduler. It sequences the single-round encryption datapath and the on-the-fly key-expansion unit.
- On start it optionally runs key expansion into the round-key store, then drives the initial AddRoundKey, rounds 1..NR-1 and the final round.
- It presents the result with a valid/ready handshake.
- It sits between the host interface and the round/key datapath, as the top-level control for the encryption core.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_rcon_gen.sv | 35 +++
 rtl/aes_round_sched.sv | 134 +++++++++++++
 tb/tb_aes_round_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and GF(2^8) helper for the AES-128 core
package aes_pkg;

    localparam int         NR_DEFAULT = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYGEN = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// rtl/aes_rcon_gen.sv - round-constant register with load-to-01 and xtime step
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] rcon_o
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    // Load wins over step so a fresh expansion always begins from 01.
    always_comb begin
        rcon_d = rcon_q;
        if (load_i) begin
            rcon_d = RCON_INIT;
        end else if (step_i) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - iterative AES-128 round and key-expansion scheduler
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          new_key,
    output logic          ready,
    output logic          keys_valid,
    output logic          key_we,
    output logic [RW-1:0] key_addr,
    output logic [7:0]    rcon,
    output logic          st_load,
    output logic          rnd_en,
    output logic          last_rnd,
    output logic [RW-1:0] round,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam logic [RW-1:0] NR_W    = RW'(NR);
    localparam logic [RW-1:0] NR_M1_W = RW'(NR - 1);
    localparam logic [RW-1:0] ONE_W   = RW'(1);

    state_e        state_q;
    state_e        state_d;
    logic [RW-1:0] round_q;
    logic [RW-1:0] round_d;
    logic [RW-1:0] key_addr_q;
    logic [RW-1:0] key_addr_d;
    logic          keys_valid_q;
    logic          keys_valid_d;
    logic          rcon_load;
    logic          rcon_step;

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        key_addr_d   = key_addr_q;
        keys_valid_d = keys_valid_q;
        rcon_load    = 1'b0;
        rcon_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (new_key || !keys_valid_q) begin
                        state_d      = ST_KEYGEN;
                        key_addr_d   = ONE_W;
                        keys_valid_d = 1'b0;
                        rcon_load    = 1'b1;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
            end
            ST_KEYGEN: begin
                rcon_step = 1'b1;
                if (key_addr_q == NR_W) begin
                    state_d      = ST_INIT;
                    key_addr_d   = '0;
                    keys_valid_d = 1'b1;
                end else begin
                    key_addr_d = key_addr_q + ONE_W;
                end
            end
            ST_INIT: begin
                state_d    = ST_ROUND;
                round_d    = ONE_W;
                key_addr_d = ONE_W;
            end
            // Round key index tracks the round number while encrypting.
            ST_ROUND: begin
                round_d    = round_q + ONE_W;
                key_addr_d = round_q + ONE_W;
                if (round_q == NR_M1_W) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d    = ST_IDLE;
                    round_d    = '0;
                    key_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                round_d    = '0;
                key_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            round_q      <= '0;
            key_addr_q   <= '0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            key_addr_q   <= key_addr_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (rcon_load),
        .step_i (rcon_step),
        .rcon_o (rcon)
    );

    // Strobes decode from registered state only, so no input reaches an output.
    assign ready      = (state_q == ST_IDLE);
    assign key_we     = (state_q == ST_KEYGEN);
    assign st_load    = (state_q == ST_INIT);
    assign rnd_en     = (state_q == ST_ROUND) || (state_q == ST_FINAL);
    assign last_rnd   = (state_q == ST_FINAL);
    assign out_valid  = (state_q == ST_DONE);
    assign round      = round_q;
    assign key_addr   = key_addr_q;
    assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// tb/tb_aes_round_sched.sv - scoreboard bench for the AES round scheduler
module tb_aes_round_sched;

    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          new_key;
    logic          out_ready;
    logic          ready;
    logic          keys_valid;
    logic          key_we;
    logic [RW-1:0] key_addr;
    logic [7:0]    rcon;
    logic          st_load;
    logic          rnd_en;
    logic          last_rnd;
    logic [RW-1:0] round;
    logic          out_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic          ready;
        logic          keys_valid;
        logic          key_we;
        logic          st_load;
        logic          rnd_en;
        logic          last_rnd;
        logic          out_valid;
        logic [RW-1:0] key_addr;
        logic [RW-1:0] round;
        logic [7:0]    rcon;
    } cyc_t;

    cyc_t       sb_q[$];
    logic [7:0] rcon_tab[NR];

    always #5 clk = ~clk;

    aes_round_sched #(.NR(NR), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .new_key    (new_key),
        .ready      (ready),
        .keys_valid (keys_valid),
        .key_we     (key_we),
        .key_addr   (key_addr),
        .rcon       (rcon),
        .st_load    (st_load),
        .rnd_en     (rnd_en),
        .last_rnd   (last_rnd),
        .round      (round),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic cyc_t observe();
        cyc_t o;
        o.ready      = ready;
        o.keys_valid = keys_valid;
        o.key_we     = key_we;
        o.st_load    = st_load;
        o.rnd_en     = rnd_en;
        o.last_rnd   = last_rnd;
        o.out_valid  = out_valid;
        o.key_addr   = key_addr;
        o.round      = round;
        o.rcon       = rcon;
        return o;
    endfunction

    // Expected per-cycle outputs from the cycle after start is accepted up to the first DONE cycle.
    function automatic void push_op(input bit keygen);
        cyc_t e;
        if (keygen) begin
            for (int k = 1; k <= NR; k++) begin
                e = '0;
                e.key_we   = 1'b1;
                e.key_addr = RW'(k);
                e.rcon     = rcon_tab[k-1];
                sb_q.push_back(e);
            end
        end
        e = '0;
        e.keys_valid = 1'b1;
        e.st_load    = 1'b1;
        sb_q.push_back(e);
        for (int r = 1; r < NR; r++) begin
            e = '0;
            e.keys_valid = 1'b1;
            e.rnd_en     = 1'b1;
            e.key_addr   = RW'(r);
            e.round      = RW'(r);
            sb_q.push_back(e);
        end
        e = '0;
        e.keys_valid = 1'b1;
        e.rnd_en     = 1'b1;
        e.last_rnd   = 1'b1;
        e.key_addr   = RW'(NR);
        e.round      = RW'(NR);
        sb_q.push_back(e);
        e = '0;
        e.keys_valid = 1'b1;
        e.out_valid  = 1'b1;
        e.key_addr   = RW'(NR);
        e.round      = RW'(NR);
        sb_q.push_back(e);
    endfunction

    task automatic run_trace(input bit noise, input int stop_round);
        cyc_t exp_c;
        cyc_t obs;
        int   cyc;
        cyc = 0;
        while (sb_q.size() > 0) begin
            tick;
            cyc++;
            start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            new_key = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_c = sb_q.pop_front();
            obs   = observe();
            checks++;
            if (obs[$bits(cyc_t)-1:8] !== exp_c[$bits(cyc_t)-1:8]) begin
                failures++;
                $display("FAIL trace cycle %0d: got rdy=%b kv=%b we=%b ld=%b en=%b lr=%b ov=%b ka=%0d rnd=%0d, want rdy=%b kv=%b we=%b ld=%b en=%b lr=%b ov=%b ka=%0d rnd=%0d",
                         cyc, obs.ready, obs.keys_valid, obs.key_we, obs.st_load, obs.rnd_en,
                         obs.last_rnd, obs.out_valid, obs.key_addr, obs.round,
                         exp_c.ready, exp_c.keys_valid, exp_c.key_we, exp_c.st_load, exp_c.rnd_en,
                         exp_c.last_rnd, exp_c.out_valid, exp_c.key_addr, exp_c.round);
            end
            if (exp_c.key_we) begin
                checks++;
                if (obs.rcon !== exp_c.rcon) begin
                    failures++;
                    $display("FAIL rcon cycle %0d: got %h want %h", cyc, obs.rcon, exp_c.rcon);
                end
            end
            if (stop_round != 0 && exp_c.rnd_en && !exp_c.last_rnd && exp_c.round == RW'(stop_round)) begin
                break;
            end
        end
        start   = 1'b0;
        new_key = 1'b0;
    endtask

    task automatic begin_op(input bit nk);
        start   = 1'b1;
        new_key = nk;
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL handshake: got ready=%b out_valid=%b want ready=1 out_valid=0", ready, out_valid);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        start     = 1'b0;
        new_key   = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ready !== 1'b1 || keys_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_flags: got ready=%b keys_valid=%b want 1 0", ready, keys_valid);
            end
            checks++;
            if (rcon !== 8'h01) begin
                failures++;
                $display("FAIL reset_rcon: got %h want 01", rcon);
            end
            checks++;
            if ({key_we, st_load, rnd_en, last_rnd, out_valid} !== 5'b0) begin
                failures++;
                $display("FAIL reset_strobes: got %b want 00000", {key_we, st_load, rnd_en, last_rnd, out_valid});
            end
            checks++;
            if (round !== '0 || key_addr !== '0) begin
                failures++;
                $display("FAIL reset_counters: got round=%0d key_addr=%0d want 0 0", round, key_addr);
            end
            tick;
        end
    endtask

    task automatic test_first_keygen;
        begin_op(1'b0);
        push_op(1'b1);
        run_trace(1'b0, 0);
        finish_op;
        checks++;
        if (keys_valid !== 1'b1) begin
            failures++;
            $display("FAIL keys_valid_after_keygen: got %b want 1", keys_valid);
        end
    endtask

    task automatic test_no_keygen;
        begin_op(1'b0);
        push_op(1'b0);
        run_trace(1'b0, 0);
        finish_op;
    endtask

    task automatic test_backpressure;
        begin_op(1'b0);
        push_op(1'b0);
        run_trace(1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || {ready, key_we, st_load, rnd_en} !== 4'b0) begin
                failures++;
                $display("FAIL backpressure %0d: got out_valid=%b rdy/we/ld/en=%b want 1 0000",
                         i, out_valid, {ready, key_we, st_load, rnd_en});
            end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        new_key   = 1'b1;
        tick;
        out_ready = 1'b0;
        new_key   = 1'b0;
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0 || key_we !== 1'b0 || st_load !== 1'b0) begin
            failures++;
            $display("FAIL done_start_ignored: got ready=%b out_valid=%b key_we=%b st_load=%b want 1 0 0 0",
                     ready, out_valid, key_we, st_load);
        end
        push_op(1'b0);
        run_trace(1'b0, 0);
        finish_op;
    endtask

    task automatic test_start_ignored;
        begin_op(1'b1);
        push_op(1'b1);
        run_trace(1'b1, 0);
        finish_op;
    endtask

    task automatic test_reset_mid;
        begin_op(1'b0);
        push_op(1'b0);
        run_trace(1'b0, 5);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        sb_q.delete();
        checks++;
        if (ready !== 1'b1 || out_valid !== 1'b0 || keys_valid !== 1'b0 || rnd_en !== 1'b0 || round !== '0) begin
            failures++;
            $display("FAIL reset_mid: got ready=%b out_valid=%b keys_valid=%b rnd_en=%b round=%0d want 1 0 0 0 0",
                     ready, out_valid, keys_valid, rnd_en, round);
        end
        begin_op(1'b0);
        push_op(1'b1);
        run_trace(1'b0, 0);
        finish_op;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        test_reset;
        test_first_keygen;
        test_no_keygen;
        test_backpressure;
        test_start_ignored;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
